// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_pkg
// Description : Shared constants for the debug frame sender and its serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_pkg;

    localparam logic [7:0] c_HEADER_BYTE_DEFAULT = 8'hA5;
    localparam int         c_BYTES_PER_WORD      = 4;
    localparam int         c_WORD_IDX_W          = 6;
    localparam int         c_BYTE_IDX_W          = 2;
    localparam int         c_STATE_W             = 3;

    localparam logic [c_STATE_W-1:0] c_S_IDLE      = 3'd0;
    localparam logic [c_STATE_W-1:0] c_S_SEND_HDR  = 3'd1;
    localparam logic [c_STATE_W-1:0] c_S_WAIT_HDR  = 3'd2;
    localparam logic [c_STATE_W-1:0] c_S_REQ_WORD  = 3'd3;
    localparam logic [c_STATE_W-1:0] c_S_WAIT_WORD = 3'd4;
    localparam logic [c_STATE_W-1:0] c_S_SEND_BYTE = 3'd5;
    localparam logic [c_STATE_W-1:0] c_S_WAIT_TX   = 3'd6;
    localparam logic [c_STATE_W-1:0] c_S_DONE      = 3'd7;

endpackage
`default_nettype wire

// File: rtl/word_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : word_byte_serializer
// Description : 32-bit MSB-first byte shifter with a 2-bit byte index.
// Revision    : 1.0 - initial release
// ============================================================================
module word_byte_serializer
    import debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_shift,
    output logic [7:0]  o_byte,
    output logic        o_last_byte
);

    logic [31:0]             r_shift;
    logic [c_BYTE_IDX_W-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 32'd0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_idx   <= '0;
        end else if (i_shift) begin
            r_shift <= {r_shift[23:0], 8'h00};
            r_idx   <= r_idx + 1'b1;
        end
    end

    // Byte that will sit at the top of the register after this cycle's edge,
    // so the caller can register it in the same cycle as load/shift.
    always_comb begin
        o_byte = r_shift[31:24];
        if (i_load) begin
            o_byte = i_word[31:24];
        end else if (i_shift) begin
            o_byte = r_shift[23:16];
        end
    end

    assign o_last_byte = (r_idx == c_BYTE_IDX_W'(c_BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/debug_frame_sender.sv
`default_nettype none
// ============================================================================
// Module      : debug_frame_sender
// Description : Streams a header byte plus NUM_WORDS debug words, MSB-first,
//               to a UART transmitter using a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_frame_sender
    import debug_pkg::*;
#(
    parameter int         NUM_WORDS   = 36,
    parameter logic [7:0] HEADER_BYTE = c_HEADER_BYTE_DEFAULT
) (
    input  logic                    clock,
    input  logic                    resetGral,
    input  logic                    send_req,
    input  logic                    abort,
    output logic                    word_req,
    output logic [c_WORD_IDX_W-1:0] word_addr,
    input  logic [31:0]             word_data,
    input  logic                    word_valid,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    output logic                    busy,
    output logic                    frame_done,
    output logic [7:0]              byte_count,
    output logic                    sent_flag,
    output logic                    waiting_for_word
);

    localparam logic [c_WORD_IDX_W-1:0] c_LAST_ADDR = c_WORD_IDX_W'(NUM_WORDS - 1);

    logic [c_STATE_W-1:0]    r_state, w_state_next;
    logic                    r_word_req, w_word_req;
    logic [c_WORD_IDX_W-1:0] r_word_addr, w_word_addr;
    logic                    r_tx_start, w_tx_start;
    logic [7:0]              r_tx_data, w_tx_data;
    logic                    r_frame_done, w_frame_done;
    logic [7:0]              r_byte_count, w_byte_count;
    logic                    r_sent_flag, w_sent_flag;
    logic                    r_busy, r_waiting;
    logic                    w_load, w_shift, w_last_byte;
    logic [7:0]              w_ser_byte;

    word_byte_serializer u_serializer (
        .clk         (clock),
        .rst_n       (resetGral),
        .i_load      (w_load),
        .i_word      (word_data),
        .i_shift     (w_shift),
        .o_byte      (w_ser_byte),
        .o_last_byte (w_last_byte)
    );

    always_comb begin
        w_state_next = r_state;
        w_word_req   = r_word_req;
        w_word_addr  = r_word_addr;
        w_tx_start   = 1'b0;
        w_tx_data    = r_tx_data;
        w_frame_done = 1'b0;
        w_byte_count = r_byte_count;
        w_sent_flag  = r_sent_flag;
        w_load       = 1'b0;
        w_shift      = 1'b0;

        // Abort overrides every transition, including a start request in IDLE.
        if (abort) begin
            w_state_next = c_S_IDLE;
            w_word_req   = 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (send_req) begin
                        w_byte_count = 8'd0;
                        w_sent_flag  = 1'b0;
                        w_word_addr  = '0;
                        w_tx_start   = 1'b1;
                        w_tx_data    = HEADER_BYTE;
                        w_state_next = c_S_SEND_HDR;
                    end
                end
                c_S_SEND_HDR: w_state_next = c_S_WAIT_HDR;
                c_S_WAIT_HDR: begin
                    if (tx_done) begin
                        w_byte_count = r_byte_count + 8'd1;
                        w_word_req   = 1'b1;
                        w_state_next = c_S_REQ_WORD;
                    end
                end
                c_S_REQ_WORD: w_state_next = c_S_WAIT_WORD;
                c_S_WAIT_WORD: begin
                    if (word_valid) begin
                        w_load       = 1'b1;
                        w_word_req   = 1'b0;
                        w_tx_start   = 1'b1;
                        w_tx_data    = w_ser_byte;
                        w_state_next = c_S_SEND_BYTE;
                    end
                end
                c_S_SEND_BYTE: w_state_next = c_S_WAIT_TX;
                c_S_WAIT_TX: begin
                    if (tx_done) begin
                        w_byte_count = r_byte_count + 8'd1;
                        w_shift      = 1'b1;
                        if (!w_last_byte) begin
                            w_tx_start   = 1'b1;
                            w_tx_data    = w_ser_byte;
                            w_state_next = c_S_SEND_BYTE;
                        end else if (r_word_addr < c_LAST_ADDR) begin
                            w_word_addr  = r_word_addr + 1'b1;
                            w_word_req   = 1'b1;
                            w_state_next = c_S_REQ_WORD;
                        end else begin
                            w_frame_done = 1'b1;
                            w_sent_flag  = 1'b1;
                            w_state_next = c_S_DONE;
                        end
                    end
                end
                c_S_DONE: w_state_next = c_S_IDLE;
                default:  w_state_next = c_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetGral) begin
        if (!resetGral) begin
            r_state      <= c_S_IDLE;
            r_word_req   <= 1'b0;
            r_word_addr  <= '0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'd0;
            r_frame_done <= 1'b0;
            r_byte_count <= 8'd0;
            r_sent_flag  <= 1'b0;
            r_busy       <= 1'b0;
            r_waiting    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_word_req   <= w_word_req;
            r_word_addr  <= w_word_addr;
            r_tx_start   <= w_tx_start;
            r_tx_data    <= w_tx_data;
            r_frame_done <= w_frame_done;
            r_byte_count <= w_byte_count;
            r_sent_flag  <= w_sent_flag;
            r_busy       <= (w_state_next != c_S_IDLE);
            r_waiting    <= (w_state_next == c_S_WAIT_WORD);
        end
    end

    assign word_req         = r_word_req;
    assign word_addr        = r_word_addr;
    assign tx_start         = r_tx_start;
    assign tx_data          = r_tx_data;
    assign busy             = r_busy;
    assign frame_done       = r_frame_done;
    assign byte_count       = r_byte_count;
    assign sent_flag        = r_sent_flag;
    assign waiting_for_word = r_waiting;

endmodule
`default_nettype wire

// File: doc/debug_frame_sender.md
Name: debug_frame_sender

Overview:
- Downstream consumer of the datapath debug unit: on a send request it streams a snapshot of NUM_WORDS debug words (register file, PC, pipeline latches) to the UART transmitter, byte by byte.
- Sequences the word fetch from the debug register bank, splits each 32-bit word MSB-first and runs the UART TX start/done handshake.
- Drives the byte counter, sent flag and waiting indicators exported to the board LEDs and pins.

Parameters:
- NUM_WORDS, 36, number of 32-bit words per frame (1..63).
- HEADER_BYTE, 8'hA5, sync byte sent before the first word byte.

Ports:
- clock  in  1  system clock (datapath clock domain).
- resetGral  in  1  asynchronous, active-low reset.
- send_req  in  1  one-cycle pulse; starts a frame when idle.
- abort  in  1  level; cancels the frame in progress.
- word_req  out  1  request to the debug bank; held until word_valid.
- word_addr  out  6  index of the requested word, 0..NUM_WORDS-1.
- word_data  in  32  word returned by the debug bank.
- word_valid  in  1  word_data valid this cycle.
- tx_start  out  1  one-cycle pulse to the UART TX.
- tx_data  out  8  byte for the UART TX; stable from tx_start until tx_done.
- tx_done  in  1  one-cycle pulse when the UART TX finishes a byte.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last byte's tx_done.
- byte_count  out  8  bytes completed in the current frame, header included.
- sent_flag  out  1  set at frame_done, cleared by the next accepted send_req.
- waiting_for_word  out  1  high while in WAIT_WORD.

Behaviour:
- Reset (resetGral=0, asynchronous): state IDLE; word_req=0, word_addr=0, tx_start=0, tx_data=0, busy=0, frame_done=0, byte_count=0, sent_flag=0, waiting_for_word=0.
- All outputs are registered.
- States: IDLE, SEND_HDR, WAIT_HDR, REQ_WORD, WAIT_WORD, SEND_BYTE, WAIT_TX, DONE.
- IDLE, send_req=1:
  - clear byte_count, sent_flag and word_addr;
  - go to SEND_HDR.
- SEND_HDR: tx_data=HEADER_BYTE, tx_start=1 for one cycle; go to WAIT_HDR.
- WAIT_HDR: on tx_done, byte_count+1, go to REQ_WORD.
- REQ_WORD: assert word_req; go to WAIT_WORD.
- WAIT_WORD:
  - word_req and waiting_for_word held high;
  - on word_valid, capture word_data into a shift register, drop word_req, clear the byte index, go to SEND_BYTE;
  - word_valid outside WAIT_WORD is ignored.
- SEND_BYTE:
  - tx_data = shift[31:24], tx_start=1 for one cycle;
  - go to WAIT_TX.
- WAIT_TX, on tx_done:
  - byte_count+1; shift register left by 8; byte index+1;
  - byte index < 4: go to SEND_BYTE;
  - otherwise, if word_addr < NUM_WORDS-1: word_addr+1, go to REQ_WORD;
  - otherwise go to DONE.
- DONE: frame_done=1 for one cycle, sent_flag=1; go to IDLE.
- Latency:
  - send_req at cycle 0 gives tx_start at cycle 1.
  - word_valid at cycle k gives tx_start at cycle k+1.
  - tx_done at cycle k gives the next tx_start at cycle k+1 within a word.
  - tx_done at cycle k gives word_req at cycle k+1 at a word boundary.
- Frame length: 1 + 4*NUM_WORDS bytes. byte_count wraps modulo 256 and does not saturate (NUM_WORDS=63 gives 253).
- send_req while busy: ignored, with no effect on counters.
- tx_done outside WAIT_HDR and WAIT_TX: ignored.
- abort (checked before all other transitions), in any non-IDLE state:
  - next cycle state=IDLE, word_req=0, tx_start=0;
  - byte_count holds its value, sent_flag stays 0, frame_done is not pulsed.
- abort together with send_req in IDLE: abort wins and the frame does not start.
- Reset mid-frame: immediate return to reset values; no partial-frame pulses.

Decomposition:
- Shared package debug_pkg:
  - state encoding constants;
  - HEADER_BYTE default;
  - BYTES_PER_WORD=4;
  - word-index width (6).
- One natural sub-module: word_byte_serializer. It holds the 32-bit shift register and 2-bit byte index, with load, shift and last_byte outputs. The FSM and counters stay in debug_frame_sender.

Test Plan:
- Reset then idle: resetGral=0 for 3 cycles, then released → all outputs 0, no tx_start for 20 cycles.
- NUM_WORDS=2 frame:
  - stimulus: word 0 = 32'h11223344, word 1 = 32'hDEADBEEF, UART model returns tx_done 10 cycles after each tx_start;
  - required tx_data sequence: A5,11,22,33,44,DE,AD,BE,EF;
  - byte_count ends at 9; frame_done pulses once; sent_flag=1.
- Slow debug bank: word_valid delayed 7 cycles after word_req → word_req and waiting_for_word high all 7 cycles; tx_start exactly 1 cycle after word_valid.
- send_req pulsed during WAIT_TX of byte 3 → ignored; frame completes normally; byte_count=9 for NUM_WORDS=2.
- abort asserted in WAIT_TX after byte_count=5 → IDLE next cycle, byte_count holds 5, no frame_done, sent_flag=0. A following send_req restarts with the header byte A5.
- NUM_WORDS=63 full frame → 253 bytes sent; byte_count=253; word_addr reaches 62; spurious tx_done injected in IDLE has no effect.
